priority_decoder: RTL

PRIORITY_DECODER -- requirements
Module: priority_decoder

---
 rtl/priority_decoder_pkg.sv | 13 +
 rtl/priority_decoder_hold_timer.sv | 29 ++
 rtl/priority_decoder.sv | 112 +++++++++++
 3 files changed

// File: rtl/priority_decoder_pkg.sv
// priority_decoder shared types.
// FSM state encoding and timer/counter width.
package priority_decoder_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/priority_decoder_hold_timer.sv
// hold_timer: loadable down-counter.
// Stops at zero; zero flag reads the stored count.
module hold_timer
  import priority_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // load has priority; count down only while nonzero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/priority_decoder.sv
// priority_decoder: index -> one-hot, held HOLD_CYCLES.
// Option: PRIORITY_DECODER_PARITY_EN adds code_par/par_err.
module priority_decoder
  import priority_decoder_pkg::*;
#(
  parameter int CODE_W      = 2,
  parameter int N_OUT       = 2**CODE_W,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code,
  input  logic              code_vld,
  output logic              code_rdy,
  output logic [N_OUT-1:0]  y,
  output logic              y_vld,
  output logic [7:0]        evt_cnt
`ifdef PRIORITY_DECODER_PARITY_EN
  ,
  input  logic              code_par,
  output logic              par_err
`endif
);

  localparam logic [CNT_W-1:0] LOAD_V =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CODE_W:0] N_LIM =
    (CODE_W+1)'(N_OUT);

  state_t            state;
  state_t            state_nx;
  logic [CODE_W-1:0] code_q;
  logic              accept;
  logic              par_bad;
  logic              good;
  logic              in_rng;
  logic              tmr_zero;
  logic              tmr_en;

  assign accept = code_vld & code_rdy;
`ifdef PRIORITY_DECODER_PARITY_EN
  assign par_bad = ^{code, code_par};
`else
  assign par_bad = 1'b0;
`endif
  assign good   = accept & ~par_bad;
  assign in_rng = ({1'b0, code} < N_LIM);
  assign tmr_en = (state == DRIVE);

  hold_timer u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (good),
    .en       (tmr_en),
    .load_val (LOAD_V),
    .zero     (tmr_zero)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (good) state_nx = DRIVE;
      DRIVE:   if (tmr_zero) state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs decoded from state and latched code
  always_comb begin
    code_rdy = (state == IDLE);
    y_vld    = (state == DRIVE);
    y        = '0;
    for (int i = 0; i < N_OUT; i++) begin
      y[i] = (state == DRIVE) &&
             ({1'b0, code_q} == (CODE_W+1)'(i));
    end
  end

  // latched code and event counter
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q  <= '0;
      evt_cnt <= '0;
    end else if (good) begin
      code_q <= code;
      if (in_rng) evt_cnt <= evt_cnt + 8'd1;
    end
  end

`ifdef PRIORITY_DECODER_PARITY_EN
  // one-cycle pulse when a bad-parity code is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err <= 1'b0;
    end else begin
      par_err <= accept & par_bad;
    end
  end
`endif

endmodule
